alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares the single combinational 4-bit `alu` (operands `a`, `b`, 3-bit `command`, result `sum`) between two requesters. Each requester presents operands and a command over a valid/ready handshake. The arbiter drives the shared `alu` instance and captures its result into a one-deep output register. The result is tagged with the requester id and delivered over a second valid/ready handshake. The block sits between the datapath clients and the `alu`; it is the only module that instantiates the `alu`.

## Interface
Parameters:
- `DATA_W`, default 4: operand/result width; fixed to the `alu` width, never overridden.
- `CMD_W`, default 3: command width; fixed to the `alu` command width, never overridden.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b` input DATA_W: requester 0 operands.
- `req0_cmd` input CMD_W: requester 0 `alu` command.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cmd`: identical set for requester 1.
- `res_valid` output 1: result register holds an undelivered result.
- `res_ready` input 1: consumer accepts the result this cycle.
- `res_data` output DATA_W: captured `alu` `sum`.
- `res_id` output 1: requester that issued the result.
- `res_cmd` output CMD_W: command that produced the result.

## Operation
- State: output register (`res_valid`, `res_data`, `res_id`, `res_cmd`) plus a 1-bit priority pointer `prio` (requester that wins a tie).
- The output register is either EMPTY (`res_valid`=0) or FULL (`res_valid`=1).
- `can_accept` = !`res_valid` | `res_ready`.
- Selection, evaluated every cycle:
  - Only `reqN_valid` high: select N.
  - Both valid: select `prio`.
  - Neither valid: no selection; the `alu` inputs are driven from requester `prio` (don't-care).
- The `alu` `a`, `b` and `command` inputs are muxed from the selected requester.
- `reqN_ready` = `can_accept` & `reqN_valid` & (selected == N). This is combinational and never high for both requesters in the same cycle.
- On accept (any `reqN_ready` high), at the clock edge:
  - `res_data` <= `alu` `sum`.
  - `res_id` <= N.
  - `res_cmd` <= `reqN_cmd`.
  - `res_valid` <= 1.
  - `prio` <= ~N.
- On drain with no accept (`res_valid` & `res_ready` and no `reqN_ready`): `res_valid` <= 0. `res_data`, `res_id` and `res_cmd` keep their last values.
- Drain and accept in the same cycle: the register reloads with the new result and `res_valid` stays 1.
- While FULL and `res_ready`=0, all result outputs hold stable and both ready outputs are 0.
- Requesters hold valid and operands stable until ready. The arbiter does not check this.
- Arithmetic: `res_data` is exactly the `alu` `sum` for the captured operands. Overflow and truncation are the `alu`'s; the arbiter adds no width change.

## Timing
- Reset (`rst`=1 at an edge):
  - `res_valid`=0, `res_data`=0, `res_id`=0, `res_cmd`=0, `prio`=0 (requester 0 wins the first tie).
  - `req0_ready`=`req1_ready`=0 while `rst` is high.
- Reset mid-operation discards any held result without delivering it. Requests pending during reset are not accepted and must be re-presented, or simply held, after reset.
- Latency: a request accepted at edge t gives `res_valid`=1 with its result from just after t until the edge where `res_ready`=1.
- Throughput: with `res_ready` held high, one result per cycle.
- Fairness: with both requesters continuously valid and `res_ready`=1, grants alternate 0,1,0,1,… with no requester waiting more than one accept.
- Backpressure: with `res_ready`=0, at most one result is buffered and nothing further is accepted.

## Test plan
- Reset, then `req0_valid`=1, a=10, b=1, cmd=3'b001, `res_ready`=1 → `req0_ready`=1 in that cycle; next cycle `res_valid`=1, `res_id`=0, `res_cmd`=001, `res_data` equals a standalone `alu`(10,1,001).
- Both requesters valid continuously (req0: a=11, b=5, cmd=011; req1: a=15, b=12, cmd=101), `res_ready`=1 → `res_id` sequence 0,1,0,1 over 4 cycles, each `res_data` matching the reference `alu`.
- Result FULL with `res_ready`=0 for 5 cycles while both requesters are valid → both ready outputs 0 and outputs stable; raise `res_ready` → same-cycle drain and accept, `res_valid` stays 1, next `res_id` follows `prio`.
- `rst` asserted for 1 cycle while `res_valid`=1 and `req1_valid`=1 → next cycle all outputs 0; after reset req1 is accepted first (only requester valid).
- Single requester 1 valid back-to-back 8 ops sweeping cmd 000–111 with a=12, b=15 → 8 results with `res_id`=1 and `res_cmd` 000…111 in order, no bubbles.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready
// requesters; results are tagged with the requester id in a one-deep output register.
//
// state   | meaning
// S_EMPTY | output register holds no undelivered result
// S_FULL  | output register holds a result awaiting res_ready

module alu #(
  parameter int DATA_W = 4,
  parameter int CMD_W  = 3
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CMD_W-1:0]  command,
  output logic [DATA_W-1:0] sum
);
  // Results wrap to DATA_W; shifts are logical.
  always_comb begin
    sum = '0;
    case (command)
      3'd0:    sum = a + b;
      3'd1:    sum = a - b;
      3'd2:    sum = a & b;
      3'd3:    sum = a | b;
      3'd4:    sum = a ^ b;
      3'd5:    sum = b - a;
      3'd6:    sum = a << 1;
      3'd7:    sum = a >> 1;
      default: sum = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_W = 4,
  parameter int CMD_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CMD_W-1:0]  req1_cmd,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic [CMD_W-1:0]  res_cmd
);
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic [DATA_W-1:0] r_data;
  logic              r_id;
  logic [CMD_W-1:0]  r_cmd;

  logic              w_sel;
  logic              w_can_accept;
  logic              w_accept;
  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [CMD_W-1:0]  w_alu_cmd;
  logic [DATA_W-1:0] w_alu_sum;

  // A lone valid requester wins; a tie (or idle) falls to the priority pointer.
  always_comb begin
    w_sel = r_prio;
    if (req0_valid && !req1_valid) begin
      w_sel = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      w_sel = 1'b1;
    end
  end

  assign w_alu_a   = w_sel ? req1_a   : req0_a;
  assign w_alu_b   = w_sel ? req1_b   : req0_b;
  assign w_alu_cmd = w_sel ? req1_cmd : req0_cmd;

  alu #(
    .DATA_W (DATA_W),
    .CMD_W  (CMD_W)
  ) u_alu (
    .a       (w_alu_a),
    .b       (w_alu_b),
    .command (w_alu_cmd),
    .sum     (w_alu_sum)
  );

  assign w_can_accept = (r_state == S_EMPTY) || res_ready;
  assign req0_ready   = !rst && w_can_accept && req0_valid && !w_sel;
  assign req1_ready   = !rst && w_can_accept && req1_valid &&  w_sel;
  assign w_accept     = req0_ready || req1_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (res_ready && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_prio  <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_cmd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data <= w_alu_sum;
        r_id   <= w_sel;
        r_cmd  <= w_alu_cmd;
        r_prio <= ~w_sel;
      end
    end
  end

  assign res_valid = (r_state == S_FULL);
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign res_cmd   = r_cmd;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes hand-computed results into a
// scoreboard queue that a negedge monitor drains on each delivered result.

module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic [2:0] req0_cmd;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic [2:0] req1_cmd;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       res_id;
  logic [2:0] res_cmd;

  typedef struct packed {
    logic       id;
    logic [2:0] cmd;
    logic [3:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cmd   (req0_cmd),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cmd   (req1_cmd),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_cmd    (res_cmd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [2:0] cmd, input logic [3:0] data);
    exp_t e;
    e.id   = id;
    e.cmd  = cmd;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every delivered result must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("mon_res_id",   32'(res_id),   32'(e.id));
          chk("mon_res_cmd",  32'(res_cmd),  32'(e.cmd));
          chk("mon_res_data", 32'(res_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // a=12, b=15 for cmd 0..7
  logic [3:0] sweep_exp [8] = '{4'd11, 4'd13, 4'd12, 4'd15, 4'd3, 4'd3, 4'd8, 4'd6};

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd10; req0_b = 4'd1;  req0_cmd = 3'b001;
    req1_valid = 1'b0; req1_a = 4'd0;  req1_b = 4'd0;  req1_cmd = 3'b000;

    // reset state; pending request must not be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid",  32'(res_valid),  32'd0);
    chk("rst_res_data",   32'(res_data),   32'd0);
    chk("rst_res_id",     32'(res_id),     32'd0);
    chk("rst_res_cmd",    32'(res_cmd),    32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);

    // single op from requester 0: 10-1 = 9
    step();
    rst = 1'b0;
    push(1'b0, 3'b001, 4'd9);
    @(negedge clk);
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // fairness: both valid, expect 0,1,0,1 (11|5=15, 12-15=13)
    req0_a = 4'd11; req0_b = 4'd5;  req0_cmd = 3'b011;
    req1_a = 4'd15; req1_b = 4'd12; req1_cmd = 3'b101;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push(1'b0, 3'b011, 4'd15);
      else            push(1'b1, 3'b101, 4'd13);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_req0_ready", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_req1_ready", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end

    // backpressure: FULL holding last id1 result, both valid, nothing accepted
    res_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_req0_ready", 32'(req0_ready), 32'd0);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      chk("bp_res_valid",  32'(res_valid),  32'd1);
      chk("bp_res_data",   32'(res_data),   32'd13);
      chk("bp_res_id",     32'(res_id),     32'd1);
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("dr_req0_ready", 32'(req0_ready), 32'd1);
    chk("dr_req1_ready", 32'(req1_ready), 32'd0);
    step();
    res_ready = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("dr_res_valid",  32'(res_valid),  32'd1);
    chk("dr_res_id",     32'(res_id),     32'd0);
    chk("dr_res_cmd",    32'(res_cmd),    32'd3);
    chk("dr_res_data",   32'(res_data),   32'd15);
    chk("dr_req1_ready", 32'(req1_ready), 32'd0);

    // reset while FULL with req1 pending: result discarded
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_req1_ready", 32'(req1_ready), 32'd0);
    step();
    rst = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("mr_res_valid",  32'(res_valid),  32'd0);
    chk("mr_res_data",   32'(res_data),   32'd0);
    chk("mr_res_id",     32'(res_id),     32'd0);
    chk("mr_res_cmd",    32'(res_cmd),    32'd0);
    chk("mr_req1_ready", 32'(req1_ready), 32'd1);
    push(1'b1, 3'b101, 4'd13);
    step();

    // requester 1 back-to-back sweep of all commands
    req1_a = 4'd12; req1_b = 4'd15;
    for (int i = 0; i < 8; i++) begin
      req1_cmd = 3'(i);
      push(1'b1, 3'(i), sweep_exp[i]);
      @(negedge clk);
      chk("sw_req1_ready", 32'(req1_ready), 32'd1);
      step();
    end
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("end_res_valid", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
